jump_hazard_ctrl: RTL

- Controller for the decode-stage jump unit. Generates the jump unit's operand forward selects, inserts load-use stalls when a branch or jalr operand is not yet available, and sequences the IF flush after a taken redirect.
- Sits beside the jump unit in ID and drives the IF/ID stall, ID/EX bubble and IF kill controls.
- Keeps saturating stall and flush event counters for performance monitoring.

---
 rtl/jump_hazard_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/jump_hazard_ctrl.sv
// jump_hazard_ctrl: decode-stage jump unit forwarding, load-use stall and IF flush sequencing.
module jump_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_is_jalr,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             br_en,
  input  logic             jal_en,
  input  logic             jalr_en,
  output logic [2:0]       forward_jump_operand1,
  output logic [2:0]       forward_jump_operand2,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             redirect_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic hz, take, stall_raw, flush_raw, redirect_raw;
  // An EX-stage load is not a forwarding source; its hazard is handled by stalling.
  function automatic logic [2:0] fwd(input logic [4:0] rs, input logic [4:0] erd, input logic ew, input logic em,
                                     input logic [4:0] mrd, input logic mw, input logic mm,
                                     input logic [4:0] wrd, input logic ww);
    fwd = (rs == 5'd0) ? 3'd0 :
          (ew && !em && erd == rs) ? 3'd1 :
          (mw && mrd == rs) ? (mm ? 3'd3 : 3'd2) :
          (ww && wrd == rs) ? 3'd4 : 3'd0;
  endfunction
  assign forward_jump_operand1 = id_valid ? fwd(id_rs1, ex_rd, ex_reg_write, ex_mem_read, mem_rd,
                                                mem_reg_write, mem_mem_read, wb_rd, wb_reg_write) : 3'd0;
  assign forward_jump_operand2 = (id_valid && id_is_branch) ? fwd(id_rs2, ex_rd, ex_reg_write, ex_mem_read, mem_rd,
                                                mem_reg_write, mem_mem_read, wb_rd, wb_reg_write) : 3'd0;
  assign hz = id_valid && (id_is_branch || id_is_jalr) && ex_mem_read && ex_reg_write && ex_rd != 5'd0 &&
              (ex_rd == id_rs1 || (id_is_branch && ex_rd == id_rs2));
  assign take = id_valid && (br_en || jal_en || jalr_en);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stall_raw = 1'b0;
    flush_raw = 1'b0;
    redirect_raw = 1'b0;
    case (state)
      RUN: begin
        if (hz) begin
          stall_raw = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_n = LDSTALL;
            cnt_n = 3'(LOAD_STALL_CYCLES - 1);
          end
        end else if (take) begin
          redirect_raw = 1'b1;
          flush_raw = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_n = FLUSH;
            cnt_n = 3'(FLUSH_CYCLES - 2);
          end
        end
      end
      LDSTALL: begin
        stall_raw = 1'b1;
        cnt_n = cnt - 3'd1;
        state_n = (cnt == 3'd1) ? RUN : LDSTALL;
      end
      FLUSH: begin
        flush_raw = 1'b1;
        cnt_n = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
        state_n = (cnt == 3'd0) ? RUN : FLUSH;
      end
      default: state_n = RUN;
    endcase
  end
  assign stall_if = rst_n && stall_raw;
  assign bubble_ex = rst_n && stall_raw;
  assign flush_if = rst_n && flush_raw;
  assign redirect_valid = rst_n && redirect_raw;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (stall_if && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
      if (redirect_valid && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule
